// File: rtl/pcint_ctrl.sv
//==============================================================================
// Module      : pcint_ctrl
// Description : Pin-change interrupt controller. Provides three I/O-mapped
//               registers: PCMSK (per-pin enable), PCCTL (global enable and
//               edge mode) and PCPND (pending flags, write-1-to-clear).
//               A pin event sets its pending flag. The interrupt request is
//               raised while PCIE is set and any flag is pending.
//               Optional feature macro: PCINT_GLITCH_FLT_EN inserts a
//               two-sample per-pin glitch filter ahead of edge detection.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pcint_ctrl #(
  parameter logic [5:0] pcmsk_adr = 6'h0C,
  parameter logic [5:0] pcctl_adr = 6'h0D,
  parameter logic [5:0] pcpnd_adr = 6'h0E,
  parameter int         pin_width = 8
) (
  input  logic                 cp2,
  input  logic                 ireset,
  input  logic [5:0]           adr,
  input  logic [7:0]           dbus_in,
  output logic [7:0]           dbus_out,
  input  logic                 iore,
  input  logic                 iowe,
  output logic                 io_out_en,
  input  logic [pin_width-1:0] pin_in,
  output logic                 irq,
  input  logic                 irqack
);

  // Architectural state
  logic [pin_width-1:0] pcmsk_q;
  logic                 pcie_q;
  logic [1:0]           mode_q;
  logic [pin_width-1:0] pcpnd_q;
  logic [pin_width-1:0] pcpnd_d;
  logic [pin_width-1:0] prev_q;
  logic                 armed_q;

  // Decode
  logic sel_msk;
  logic sel_ctl;
  logic sel_pnd;
  logic wr_msk;
  logic wr_ctl;
  logic wr_pnd;

  // Datapath
  logic [pin_width-1:0] lvl;
  logic [pin_width-1:0] edge_vec;
  logic [pin_width-1:0] set_vec;
  logic [pin_width-1:0] clr_vec;
  logic [7:0]           msk8;
  logic [7:0]           pnd8;

  assign sel_msk   = (adr == pcmsk_adr);
  assign sel_ctl   = (adr == pcctl_adr);
  assign sel_pnd   = (adr == pcpnd_adr);
  assign wr_msk    = iowe & sel_msk;
  assign wr_ctl    = iowe & sel_ctl;
  assign wr_pnd    = iowe & sel_pnd;
  assign io_out_en = iore & (sel_msk | sel_ctl | sel_pnd);

`ifdef PCINT_GLITCH_FLT_EN
  // Set when the pin disagreed with the filtered level on the previous sample.
  logic [pin_width-1:0] dis_q;

  // The filtered level flips on the second consecutive disagreeing sample.
  // prev_q holds the filtered level, so edges are seen one cycle later.
  assign lvl = prev_q ^ ((pin_in ^ prev_q) & dis_q);

  // Track a first disagreement; a second one is consumed by the level flip.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      dis_q <= '0;
    end else if (!armed_q) begin
      dis_q <= '0;
    end else begin
      dis_q <= (pin_in ^ prev_q) & ~dis_q;
    end
  end
`else
  assign lvl = pin_in;
`endif

  // Edge vector selected by MODE; suppressed until the first sample is held.
  always_comb begin
    edge_vec = '0;
    case (mode_q)
      2'b00:   edge_vec = lvl ^ prev_q;
      2'b01:   edge_vec = ~lvl & prev_q;
      2'b10:   edge_vec = lvl & ~prev_q;
      default: edge_vec = '0;
    endcase
    if (!armed_q) begin
      edge_vec = '0;
    end
  end

  // Set beats clear so an edge coinciding with an acknowledge is kept.
  always_comb begin
    set_vec = edge_vec & pcmsk_q;
    clr_vec = '0;
    if (irqack) begin
      clr_vec = '1;
    end else if (wr_pnd) begin
      clr_vec = dbus_in[pin_width-1:0];
    end
    pcpnd_d = (pcpnd_q & ~clr_vec) | set_vec;
  end

  // Arm after the first post-reset sample; track pin history every cycle.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      armed_q <= 1'b0;
      prev_q  <= '0;
    end else begin
      armed_q <= 1'b1;
      prev_q  <= armed_q ? lvl : pin_in;
    end
  end

  // Control, mask and pending register updates.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      pcmsk_q <= '0;
      pcie_q  <= 1'b0;
      mode_q  <= 2'b00;
      pcpnd_q <= '0;
    end else begin
      if (wr_msk) begin
        pcmsk_q <= dbus_in[pin_width-1:0];
      end
      if (wr_ctl) begin
        pcie_q <= dbus_in[7];
        mode_q <= dbus_in[1:0];
      end
      pcpnd_q <= pcpnd_d;
    end
  end

  // Request derived directly from registered state; reset clears it at once.
  assign irq = pcie_q & (|pcpnd_q);

  // Zero-extended register images and read-data mux.
  always_comb begin
    msk8                  = 8'h00;
    pnd8                  = 8'h00;
    msk8[pin_width-1:0]   = pcmsk_q;
    pnd8[pin_width-1:0]   = pcpnd_q;
    dbus_out              = 8'h00;
    if (sel_msk) begin
      dbus_out = msk8;
    end else if (sel_ctl) begin
      dbus_out = {pcie_q, 5'b00000, mode_q};
    end else if (sel_pnd) begin
      dbus_out = pnd8;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pcint_ctrl.sv
//==============================================================================
// Module      : tb_pcint_ctrl
// Description : Self-checking bench for pcint_ctrl with a queue of expected
//               values. Honours PCINT_GLITCH_FLT_EN for the extra cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pcint_ctrl;

`ifdef PCINT_GLITCH_FLT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  localparam logic [5:0] A_MSK = 6'h0C;
  localparam logic [5:0] A_CTL = 6'h0D;
  localparam logic [5:0] A_PND = 6'h0E;

  logic       cp2;
  logic       ireset;
  logic [5:0] adr;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       iore;
  logic       iowe;
  logic       io_out_en;
  logic [7:0] pin_in;
  logic       irq;
  logic       irqack;

  typedef struct {
    string      nm;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         checks;
  int         errors;
  logic [7:0] rd;
  logic       en;

  pcint_ctrl dut (
    .cp2       (cp2),
    .ireset    (ireset),
    .adr       (adr),
    .dbus_in   (dbus_in),
    .dbus_out  (dbus_out),
    .iore      (iore),
    .iowe      (iowe),
    .io_out_en (io_out_en),
    .pin_in    (pin_in),
    .irq       (irq),
    .irqack    (irqack)
  );

  initial cp2 = 1'b0;
  always #5 cp2 = ~cp2;

  task automatic tick();
    @(posedge cp2);
    #1;
  endtask

  task automatic settle();
    repeat (1 + LAT) tick();
  endtask

  task automatic io_write(input logic [5:0] a, input logic [7:0] d);
    adr     = a;
    dbus_in = d;
    iowe    = 1'b1;
    tick();
    iowe    = 1'b0;
    adr     = 6'h00;
  endtask

  task automatic io_read(input logic [5:0] a, output logic [7:0] d, output logic oe);
    adr  = a;
    iore = 1'b1;
    #1;
    d    = dbus_out;
    oe   = io_out_en;
    iore = 1'b0;
    adr  = 6'h00;
  endtask

  task automatic test_reset();
    ireset = 1'b0;
    pin_in = 8'hFF;
    repeat (2) tick();
    sb.push_back('{"rst_irq", 8'h00});
    sb.push_back('{"rst_pcctl", 8'h00});
    sb.push_back('{"rst_pcpnd", 8'h00});
    e = sb.pop_front(); checks++;
    if ({7'd0, irq} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, irq, e.val); end
    io_read(A_CTL, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    io_read(A_PND, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    tick();
    ireset = 1'b1;
    repeat (4) tick();
    sb.push_back('{"post_rst_pcpnd", 8'h00});
    sb.push_back('{"post_rst_irq", 8'h00});
    io_read(A_PND, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    e = sb.pop_front(); checks++;
    if ({7'd0, irq} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, irq, e.val); end
  endtask

  task automatic test_rise();
    pin_in = 8'h00;
    repeat (2 + LAT) tick();
    io_write(A_MSK, 8'h01);
    io_write(A_CTL, 8'h82);
    io_write(A_PND, 8'hFF);
    pin_in[0] = 1'b1;
    sb.push_back('{"rise_irq", 8'h01});
    sb.push_back('{"rise_pcpnd", 8'h01});
    sb.push_back('{"rise_oe", 8'h01});
    sb.push_back('{"unmapped_rd", 8'h00});
    sb.push_back('{"unmapped_oe", 8'h00});
    settle();
    e = sb.pop_front(); checks++;
    if ({7'd0, irq} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, irq, e.val); end
    io_read(A_PND, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    e = sb.pop_front(); checks++;
    if ({7'd0, en} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, en, e.val); end
    io_read(6'h20, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    e = sb.pop_front(); checks++;
    if ({7'd0, en} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, en, e.val); end
  endtask

  task automatic test_modes();
    pin_in = 8'h00;
    repeat (2 + LAT) tick();
    io_write(A_CTL, 8'h81);
    io_write(A_MSK, 8'h08);
    io_write(A_PND, 8'hFF);
    // falling mode: rise ignored, fall flagged
    pin_in[3] = 1'b1;
    sb.push_back('{"fall_mode_rise", 8'h00});
    settle();
    io_read(A_PND, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    pin_in[3] = 1'b0;
    sb.push_back('{"fall_mode_fall", 8'h08});
    settle();
    io_read(A_PND, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    // no-edge mode: toggles never flag
    io_write(A_PND, 8'hFF);
    io_write(A_CTL, 8'h83);
    pin_in[3] = 1'b1;
    repeat (2 + LAT) tick();
    pin_in[3] = 1'b0;
    sb.push_back('{"none_mode", 8'h00});
    repeat (2 + LAT) tick();
    io_read(A_PND, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    // any-change mode: rise flagged; unmasked pin ignored
    io_write(A_CTL, 8'h80);
    pin_in = 8'h18;
    sb.push_back('{"any_mode", 8'h08});
    settle();
    io_read(A_PND, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    sb.push_back('{"ctl_readback", 8'h80});
    io_read(A_CTL, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
  endtask

  task automatic test_w1c_ack();
    pin_in = 8'h00;
    repeat (2 + LAT) tick();
    io_write(A_MSK, 8'h05);
    io_write(A_CTL, 8'h80);
    io_write(A_PND, 8'hFF);
    pin_in = 8'h05;
    sb.push_back('{"two_flags", 8'h05});
    settle();
    io_read(A_PND, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    sb.push_back('{"w1c", 8'h01});
    io_write(A_PND, 8'h04);
    io_read(A_PND, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    // acknowledge on the very edge that detects a new bit-0 change
    pin_in[0] = 1'b0;
    repeat (LAT) tick();
    irqack = 1'b1;
    sb.push_back('{"ack_vs_set_pnd", 8'h01});
    sb.push_back('{"ack_vs_set_irq", 8'h01});
    tick();
    irqack = 1'b0;
    io_read(A_PND, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    e = sb.pop_front(); checks++;
    if ({7'd0, irq} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, irq, e.val); end
    // plain acknowledge clears everything
    irqack = 1'b1;
    sb.push_back('{"ack_clear_pnd", 8'h00});
    sb.push_back('{"ack_clear_irq", 8'h00});
    tick();
    irqack = 1'b0;
    io_read(A_PND, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    e = sb.pop_front(); checks++;
    if ({7'd0, irq} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, irq, e.val); end
  endtask

  task automatic test_pcie();
    pin_in = 8'h00;
    repeat (2 + LAT) tick();
    io_write(A_CTL, 8'h00);
    io_write(A_MSK, 8'h04);
    io_write(A_PND, 8'hFF);
    pin_in[2] = 1'b1;
    sb.push_back('{"pcie0_pnd", 8'h04});
    sb.push_back('{"pcie0_irq", 8'h00});
    settle();
    io_read(A_PND, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    e = sb.pop_front(); checks++;
    if ({7'd0, irq} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, irq, e.val); end
    sb.push_back('{"pcie1_irq", 8'h01});
    io_write(A_CTL, 8'h80);
    e = sb.pop_front(); checks++;
    if ({7'd0, irq} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, irq, e.val); end
    sb.push_back('{"mask_chg_keeps_pnd", 8'h04});
    io_write(A_MSK, 8'h00);
    io_read(A_PND, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    io_write(A_MSK, 8'h04);
  endtask

  task automatic test_async_reset();
    tick();
    ireset = 1'b0;
    sb.push_back('{"async_rst_irq", 8'h00});
    sb.push_back('{"async_rst_pnd", 8'h00});
    sb.push_back('{"async_rst_msk", 8'h00});
    #1;
    e = sb.pop_front(); checks++;
    if ({7'd0, irq} !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, irq, e.val); end
    io_read(A_PND, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    io_read(A_MSK, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    tick();
    ireset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_pulse();
    pin_in = 8'h00;
    repeat (3) tick();
    io_write(A_CTL, 8'h82);
    io_write(A_MSK, 8'h02);
    io_write(A_PND, 8'hFF);
    pin_in[1] = 1'b1;
    tick();
    pin_in[1] = 1'b0;
`ifdef PCINT_GLITCH_FLT_EN
    sb.push_back('{"short_pulse", 8'h00});
`else
    sb.push_back('{"short_pulse", 8'h02});
`endif
    repeat (3) tick();
    io_read(A_PND, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    io_write(A_PND, 8'hFF);
    pin_in[1] = 1'b1;
    sb.push_back('{"long_pulse_first", (LAT == 0) ? 8'h02 : 8'h00});
    sb.push_back('{"long_pulse_second", 8'h02});
    tick();
    io_read(A_PND, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    tick();
    io_read(A_PND, rd, en);
    e = sb.pop_front(); checks++;
    if (rd !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.nm, rd, e.val); end
    tick();
    pin_in[1] = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    ireset  = 1'b0;
    adr     = 6'h00;
    dbus_in = 8'h00;
    iore    = 1'b0;
    iowe    = 1'b0;
    irqack  = 1'b0;
    pin_in  = 8'hFF;
    test_reset();
    test_rise();
    test_modes();
    test_w1c_ack();
    test_pcie();
    test_async_reset();
    test_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pcint_ctrl.md
PCINT_CTRL -- requirements
Module: pcint_ctrl

Interface
REQ-001 Parameter pcmsk_adr, default 6'h0C: I/O address of PCMSK, the per-pin enable mask (R/W).
REQ-002 Parameter pcctl_adr, default 6'h0D: I/O address of PCCTL. Bit7 is PCIE, the global enable. Bits[1:0] are MODE: 00 any change, 01 falling, 10 rising, 11 none. Bits[6:2] read 0.
REQ-003 Parameter pcpnd_adr, default 6'h0E: I/O address of PCPND, the per-pin pending flags (read; write-1-to-clear).
REQ-004 Parameter pin_width, default 8, legal 1..8: number of monitored pins. Unimplemented bits of PCMSK/PCPND read 0 and ignore writes.
REQ-005 Port cp2, input, 1: the single clock; all state on rising edge.
REQ-006 Port ireset, input, 1: asynchronous, active-low reset.
REQ-007 Port adr, input, 6: I/O address.
REQ-008 Port dbus_in, input, 8: I/O write data.
REQ-009 Port dbus_out, output, 8: I/O read data; 8'h00 when no register is addressed.
REQ-010 Port iore, input, 1: I/O read strobe.
REQ-011 Port iowe, input, 1: I/O write strobe.
REQ-012 Port io_out_en, output, 1: high when iore is high and adr matches any of the three addresses; combinational.
REQ-013 Port pin_in, input, pin_width: pin levels, already resynchronised by the upstream parallel port (its resync_out).
REQ-014 Port irq, output, 1: pin-change interrupt request to the core.
REQ-015 Port irqack, input, 1: one-cycle interrupt acknowledge from the core.

Function
REQ-016 A register write SHALL occur on the cp2 edge where iowe is high and adr matches; dbus_out SHALL be a combinational mux of the addressed register.
REQ-017 Register prev SHALL hold the previous pin_in sample. Register armed SHALL be 0 after reset and go to 1 on the first cycle after reset. While armed=0, prev loads pin_in and no edge is detected (no spurious post-reset events).
REQ-018 Edge vector per bit i, when armed=1:
- MODE 00: pin_in[i]^prev[i]
- MODE 01: ~pin_in[i]&prev[i]
- MODE 10: pin_in[i]&~prev[i]
- MODE 11: 0
REQ-019 PCPND[i] SHALL be set on the cp2 edge where edge[i] is 1 and PCMSK[i] is 1. Mask and mode values used are those registered before that edge.
REQ-020 Latency: pin change present at pin_in before cp2 edge N gives PCPND and irq high immediately after edge N.
REQ-021 irq SHALL equal PCIE & (|PCPND), registered-state derived with no extra pipeline stage. PCIE=0 suppresses irq but not flag setting.
REQ-022 Writing 1 to PCPND[i] clears it; writing 0 has no effect.
REQ-023 irqack=1 SHALL clear all PCPND bits on that edge.
REQ-024 Simultaneous set and clear (W1C or irqack) on the same bit in the same cycle: set wins, so the edge is not lost.
REQ-025 Changing PCMSK or MODE SHALL NOT alter existing PCPND bits.
REQ-026 prev SHALL update every cycle regardless of mask or mode.

Reset
REQ-027 On ireset low, asynchronously: PCMSK=0, PCCTL=0, PCPND=0, prev=0, armed=0, irq=0.
REQ-028 Reset asserted mid-operation SHALL drop irq within the same cycle and discard any pending event.
REQ-029 After reset deasserts, the first edge detection occurs no earlier than the second cp2 edge.

Configuration
REQ-030 Macro PCINT_GLITCH_FLT_EN, when defined, inserts a per-pin filter ahead of edge detection.
- The filtered level updates only after pin_in differs from it on 2 consecutive samples.
- Edge detection then uses the filtered level, adding 1 cycle of latency.
- Pulses of 1 cycle are ignored.
- The filter resets to 0 and is preloaded from pin_in while armed=0.
REQ-031 When PCINT_GLITCH_FLT_EN is undefined, there is no filter and latency is per REQ-020.

Verification
REQ-032 Reset; pin_in=8'hFF held from reset release -> PCPND stays 8'h00 and irq stays 0 (no spurious edge).
REQ-033 PCMSK=8'h01, PCCTL=8'h82; pin_in[0] goes 0->1 -> PCPND=8'h01 and irq=1 after that edge. Read at 6'h0E returns 8'h01 with io_out_en=1.
REQ-034 PCCTL=8'h81 (falling); pin_in[3] rises, with PCMSK=8'h08 -> no flag. pin_in[3] then falls -> PCPND=8'h08.
REQ-035 PCPND=8'h05; write 8'h04 to pcpnd_adr -> 8'h01. irqack while a new edge on bit 0 occurs in the same cycle -> PCPND=8'h01 and irq stays 1.
REQ-036 PCCTL=8'h00 with an edge on masked bit 2 -> PCPND=8'h04, irq=0. Then write PCCTL=8'h80 -> irq=1 next cycle.
REQ-037 With PCINT_GLITCH_FLT_EN: a 1-cycle pulse on pin 1 -> no flag. A 3-cycle pulse -> PCPND[1]=1, set 1 cycle later than without the macro.
